// File: rtl/thermal_head_pkg.sv
// Shared types and default sizing for the thermal-head line sequencer.
// line_rec_t describes one line record at the default sizing, for
// consumers that pack the record into a single word.
package thermal_head_pkg;

    localparam int HEAD_WIDTH_DEFAULT  = 384;
    localparam int BITCNT_W_DEFAULT    = 16;
    localparam int BURNCNT_W_DEFAULT   = 24;
    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BURN  = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [HEAD_WIDTH_DEFAULT-1:0] dots;
        logic [BITCNT_W_DEFAULT-1:0]   bits;
        logic [BURNCNT_W_DEFAULT-1:0]  burn;
        logic                          no_latch;
        logic                          overrun;
    } line_rec_t;

endpackage

// File: rtl/signal_synchroniser.sv
// Multi-flop synchroniser for one asynchronous head pin, followed by a
// registered edge detector. Pulses appear SYNC_STAGES+1 clk after the pin.
module signal_synchroniser #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_r;
    logic                   prev_r;
    logic                   rise_r;
    logic                   fall_r;

    // Shift the raw pin through the synchroniser chain and register edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_r <= {SYNC_STAGES{1'b0}};
            prev_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            chain_r[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain_r[i] <= chain_r[i-1];
            end
            prev_r <= chain_r[SYNC_STAGES-1];
            rise_r <= chain_r[SYNC_STAGES-1] & ~prev_r;
            fall_r <= ~chain_r[SYNC_STAGES-1] & prev_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/thermal_head_line_sequencer.sv
// Watches the thermal head control pins (shift clock, LATCH#, DST) and turns
// every DST strobe into one line record offered over valid/ready.
module thermal_head_line_sequencer
    import thermal_head_pkg::*;
#(
    parameter int HEAD_WIDTH  = HEAD_WIDTH_DEFAULT,
    parameter int BITCNT_W    = BITCNT_W_DEFAULT,
    parameter int BURNCNT_W   = BURNCNT_W_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  head_clk_in,
    input  logic                  head_latch_n_in,
    input  logic                  head_dst_in,
    input  logic [HEAD_WIDTH-1:0] head_active_dots,
    output logic                  line_valid,
    input  logic                  line_ready,
    output logic [HEAD_WIDTH-1:0] line_dots,
    output logic [BITCNT_W-1:0]   line_bits,
    output logic [BURNCNT_W-1:0]  line_burn,
    output logic                  line_no_latch,
    output logic                  line_overrun,
    output logic [15:0]           dropped_lines,
    output logic [1:0]            state_o
);

    // Edge pulses from the synchronised head pins
    logic clk_rise_s, clk_fall_s;
    logic latch_rise_s, latch_fall_s;
    logic dst_rise_s, dst_fall_s;
    logic unused_edges_s;

    signal_synchroniser #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(clk), .reset(reset), .raw(head_clk_in),
        .rise(clk_rise_s), .fall(clk_fall_s)
    );
    signal_synchroniser #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
        .clk(clk), .reset(reset), .raw(head_latch_n_in),
        .rise(latch_rise_s), .fall(latch_fall_s)
    );
    signal_synchroniser #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dst (
        .clk(clk), .reset(reset), .raw(head_dst_in),
        .rise(dst_rise_s), .fall(dst_fall_s)
    );

    // Edges the sequencer has no use for
    assign unused_edges_s = clk_fall_s ^ latch_rise_s;

    // Shift / latch bookkeeping
    logic [BITCNT_W-1:0]  shift_cnt_r;
    logic [BITCNT_W-1:0]  shift_inc_s;
    logic [BITCNT_W-1:0]  latched_bits_r;
    logic                 have_latch_r;

    // Current burn
    logic [BURNCNT_W-1:0] burn_cnt_r;
    logic [BITCNT_W-1:0]  burn_bits_r;
    logic                 burn_no_latch_r;

    // FSM
    seq_state_e state_r;
    seq_state_e state_next_s;
    logic       capture_s;
    logic       burn_inc_s;
    logic       commit_s;

    // Output register and drop accounting
    logic                  out_valid_r;
    logic [HEAD_WIDTH-1:0] out_dots_r;
    logic [BITCNT_W-1:0]   out_bits_r;
    logic [BURNCNT_W-1:0]  out_burn_r;
    logic                  out_no_latch_r;
    logic                  out_overrun_r;
    logic                  out_free_s;
    logic [15:0]           dropped_r;
    logic                  drop_flag_r;

    // Saturating successor of the shift counter
    always_comb begin
        if (shift_cnt_r == {BITCNT_W{1'b1}}) begin
            shift_inc_s = shift_cnt_r;
        end else begin
            shift_inc_s = shift_cnt_r + {{(BITCNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count shift clocks; a latch hands the count over (including a coincident shift) and restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_cnt_r    <= {BITCNT_W{1'b0}};
            latched_bits_r <= {BITCNT_W{1'b0}};
            have_latch_r   <= 1'b0;
        end else if (latch_fall_s) begin
            latched_bits_r <= clk_rise_s ? shift_inc_s : shift_cnt_r;
            shift_cnt_r    <= {BITCNT_W{1'b0}};
            have_latch_r   <= 1'b1;
        end else if (clk_rise_s) begin
            shift_cnt_r <= shift_inc_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (dst_rise_s) begin
                    state_next_s = BURN;
                end else if (latch_fall_s) begin
                    state_next_s = ARMED;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ARMED: begin
                if (dst_rise_s) begin
                    state_next_s = BURN;
                end else begin
                    state_next_s = ARMED;
                end
            end
            BURN: begin
                if (dst_fall_s) begin
                    state_next_s = ARMED;
                end else begin
                    state_next_s = BURN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM control strobes: start a burn, extend it, or commit it
    always_comb begin
        capture_s  = 1'b0;
        burn_inc_s = 1'b0;
        commit_s   = 1'b0;
        case (state_r)
            IDLE, ARMED: begin
                capture_s = dst_rise_s;
            end
            BURN: begin
                commit_s   = dst_fall_s;
                burn_inc_s = ~dst_fall_s;
            end
            default: begin
                capture_s  = 1'b0;
                burn_inc_s = 1'b0;
                commit_s   = 1'b0;
            end
        endcase
    end

    // Snapshot latch context at DST rise and time the burn, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            burn_cnt_r      <= {BURNCNT_W{1'b0}};
            burn_bits_r     <= {BITCNT_W{1'b0}};
            burn_no_latch_r <= 1'b0;
        end else if (capture_s) begin
            burn_cnt_r      <= {{(BURNCNT_W-1){1'b0}}, 1'b1};
            burn_bits_r     <= latched_bits_r;
            burn_no_latch_r <= ~have_latch_r;
        end else if (burn_inc_s && (burn_cnt_r != {BURNCNT_W{1'b1}})) begin
            burn_cnt_r <= burn_cnt_r + {{(BURNCNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_free_s = ~out_valid_r | line_ready;

    // Single-entry output register; an accept and a new load may share a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r    <= 1'b0;
            out_dots_r     <= {HEAD_WIDTH{1'b0}};
            out_bits_r     <= {BITCNT_W{1'b0}};
            out_burn_r     <= {BURNCNT_W{1'b0}};
            out_no_latch_r <= 1'b0;
            out_overrun_r  <= 1'b0;
        end else if (commit_s && out_free_s) begin
            out_valid_r    <= 1'b1;
            out_dots_r     <= head_active_dots;
            out_bits_r     <= burn_bits_r;
            out_burn_r     <= burn_cnt_r;
            out_no_latch_r <= burn_no_latch_r;
            out_overrun_r  <= drop_flag_r;
        end else if (out_valid_r && line_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Count lines lost to a full output register and flag the next delivered record.
    always_ff @(posedge clk) begin
        if (reset) begin
            dropped_r   <= 16'h0000;
            drop_flag_r <= 1'b0;
        end else if (commit_s && !out_free_s) begin
            drop_flag_r <= 1'b1;
            if (dropped_r != 16'hFFFF) begin
                dropped_r <= dropped_r + 16'h0001;
            end
        end else if (commit_s) begin
            drop_flag_r <= 1'b0;
        end
    end

    assign line_valid    = out_valid_r;
    assign line_dots     = out_dots_r;
    assign line_bits     = out_bits_r;
    assign line_burn     = out_burn_r;
    assign line_no_latch = out_no_latch_r;
    assign line_overrun  = out_overrun_r;
    assign dropped_lines = dropped_r;
    assign state_o       = state_r;

endmodule
